// File: rtl/core_pkg.sv
// Shared core types: privilege levels, the local-interrupt base cause and the
// request FSM states used by core_local_irq_ctrl.
package core_pkg;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_S = 2'b01,
    PRIV_M = 2'b11
  } priv_e;

  localparam int IRQ_LOCAL_BASE = 16;
  localparam int IRQ_MAX        = 48;

  typedef enum logic [1:0] {
    IRQ_IDLE = 2'b00,
    IRQ_REQ  = 2'b01,
    IRQ_HOLD = 2'b10
  } irq_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [5:0] irq_lowest_set(input logic [IRQ_MAX-1:0] vec);
    logic [5:0] idx;
    idx = 6'd0;
    for (int i = IRQ_MAX - 1; i >= 0; i--) begin
      idx = vec[i] ? 6'(i) : idx;
    end
    return idx;
  endfunction

endpackage

// File: rtl/core_local_irq_ctrl_if.sv
// Request handshake between the local interrupt controller (master) and the
// core controller that takes the interrupt (slave).
interface core_local_irq_ctrl_if #(
  parameter int CAUSE_W = 6
);
  logic               check_interrupt;
  logic               irq_take;
  logic               irq_valid;
  logic               irq_to_s;
  logic [CAUSE_W-1:0] irq_cause;

  modport master (
    input  check_interrupt,
    input  irq_take,
    output irq_valid,
    output irq_to_s,
    output irq_cause
  );

  modport slave (
    output check_interrupt,
    output irq_take,
    input  irq_valid,
    input  irq_to_s,
    input  irq_cause
  );
endinterface

// File: rtl/core_irq_sync.sv
// Multi-flop synchroniser for one asynchronous interrupt line, plus a delayed
// copy of the synchronised value for rising-edge detection.
module core_irq_sync #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic sync_o,
  output logic dly_o
);

  logic [SYNC_STAGES-1:0] s_q;
  logic [SYNC_STAGES-1:0] s_d;
  logic                   dly_q;
  logic                   dly_d;

  always_comb begin
    s_d   = {s_q[SYNC_STAGES-2:0], d_i};
    dly_d = s_q[SYNC_STAGES-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s_q   <= {SYNC_STAGES{1'b0}};
      dly_q <= 1'b0;
    end else begin
      s_q   <= s_d;
      dly_q <= dly_d;
    end
  end

  assign sync_o = s_q[SYNC_STAGES-1];
  assign dly_o  = dly_q;

endmodule

// File: rtl/core_local_irq_ctrl.sv
// Local interrupt controller: sync, level/edge capture, M/S delegation, masking,
// fixed-priority arbitration and a registered request. Optional sticky overrun
// flags are built when CORE_IRQ_OVERRUN_EN is defined.
module core_local_irq_ctrl
  import core_pkg::*;
#(
  parameter  int NUM_IRQ     = 16,
  parameter  int SYNC_STAGES = 2,
  parameter  int CAUSE_W     = 6,
  localparam int IDX_W       = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_IRQ-1:0]   irq_i,
  input  logic [NUM_IRQ-1:0]   cfg_edge,
  input  logic [NUM_IRQ-1:0]   cfg_ie,
  input  logic [NUM_IRQ-1:0]   cfg_deleg,
  input  priv_e                priv,
  input  logic                 cfg_mie,
  input  logic                 cfg_sie,
  input  logic                 clr_valid,
  input  logic [IDX_W-1:0]     clr_idx,
  output logic [NUM_IRQ-1:0]   pending,
  output logic [NUM_IRQ-1:0]   overrun,
  core_local_irq_ctrl_if.master req_if
);

  logic [NUM_IRQ-1:0] sync_s, dly_s, rise_s, clr_s, take_vec_s;
  logic [NUM_IRQ-1:0] edge_q, edge_d;
  logic [NUM_IRQ-1:0] elig_mt_s, elig_st_s, elig_s;
  logic               m_en_s, s_en_s, take_s, win_to_s_s;
  logic [IDX_W-1:0]   win_idx_s, idx_q, idx_d;
  irq_state_e         state_q, state_d;
  logic               valid_q, valid_d, to_s_q, to_s_d;
  logic [CAUSE_W-1:0] cause_q, cause_d;

  for (genvar g = 0; g < NUM_IRQ; g++) begin : g_sync
    core_irq_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .d_i    (irq_i[g]),
      .sync_o (sync_s[g]),
      .dly_o  (dly_s[g])
    );
  end

  assign rise_s  = sync_s & ~dly_s;
  assign pending = (cfg_edge & edge_q) | (~cfg_edge & sync_s);

  always_comb begin
    m_en_s = 1'b1;
    s_en_s = 1'b1;
    case (priv)
      PRIV_M:  begin m_en_s = cfg_mie; s_en_s = 1'b0;    end
      PRIV_S:  begin m_en_s = 1'b1;    s_en_s = cfg_sie; end
      default: begin m_en_s = 1'b1;    s_en_s = 1'b1;    end
    endcase
  end

  assign elig_mt_s = pending & cfg_ie & ~cfg_deleg & {NUM_IRQ{m_en_s}};
  assign elig_st_s = pending & cfg_ie &  cfg_deleg & {NUM_IRQ{s_en_s}};
  assign elig_s    = elig_mt_s | elig_st_s;

  // M-target channels always beat S-target; lowest index wins within a target.
  always_comb begin
    win_idx_s  = {IDX_W{1'b0}};
    win_to_s_s = 1'b0;
    if (|elig_mt_s) begin
      win_idx_s  = IDX_W'(irq_lowest_set(IRQ_MAX'(elig_mt_s)));
      win_to_s_s = 1'b0;
    end else begin
      win_idx_s  = IDX_W'(irq_lowest_set(IRQ_MAX'(elig_st_s)));
      win_to_s_s = 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    valid_d = valid_q;
    to_s_d  = to_s_q;
    cause_d = cause_q;
    take_s  = 1'b0;
    case (state_q)
      IRQ_IDLE: begin
        if (req_if.check_interrupt && (|elig_s)) begin
          state_d = IRQ_REQ;
          idx_d   = win_idx_s;
          valid_d = 1'b1;
          to_s_d  = win_to_s_s;
          cause_d = CAUSE_W'(IRQ_LOCAL_BASE) + CAUSE_W'(win_idx_s);
        end else begin
          state_d = IRQ_IDLE;
          valid_d = 1'b0;
        end
      end
      IRQ_REQ: begin
        // A take in the same cycle the channel loses eligibility is still a take.
        if (req_if.irq_take) begin
          take_s  = 1'b1;
          state_d = IRQ_HOLD;
          valid_d = 1'b0;
        end else if (!elig_s[idx_q]) begin
          state_d = IRQ_IDLE;
          valid_d = 1'b0;
        end else begin
          state_d = IRQ_REQ;
          valid_d = 1'b1;
        end
      end
      IRQ_HOLD: begin
        state_d = IRQ_IDLE;
        valid_d = 1'b0;
      end
      default: begin
        state_d = IRQ_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  always_comb begin
    clr_s      = {NUM_IRQ{1'b0}};
    take_vec_s = {NUM_IRQ{1'b0}};
    edge_d     = {NUM_IRQ{1'b0}};
    for (int i = 0; i < NUM_IRQ; i++) begin
      clr_s[i]      = clr_valid && (clr_idx == IDX_W'(i));
      take_vec_s[i] = take_s && (idx_q == IDX_W'(i));
      if (cfg_edge[i]) begin
        edge_d[i] = rise_s[i] | (edge_q[i] & ~(clr_s[i] | take_vec_s[i]));
      end else begin
        edge_d[i] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IRQ_IDLE;
      idx_q   <= {IDX_W{1'b0}};
      valid_q <= 1'b0;
      to_s_q  <= 1'b0;
      cause_q <= {CAUSE_W{1'b0}};
      edge_q  <= {NUM_IRQ{1'b0}};
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      valid_q <= valid_d;
      to_s_q  <= to_s_d;
      cause_q <= cause_d;
      edge_q  <= edge_d;
    end
  end

`ifdef CORE_IRQ_OVERRUN_EN
  logic [NUM_IRQ-1:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = (cfg_edge & rise_s & edge_q) | (ovr_q & ~clr_s);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovr_q <= {NUM_IRQ{1'b0}};
    end else begin
      ovr_q <= ovr_d;
    end
  end

  assign overrun = ovr_q;
`else
  assign overrun = {NUM_IRQ{1'b0}};
`endif

  assign req_if.irq_valid = valid_q;
  assign req_if.irq_to_s  = to_s_q;
  assign req_if.irq_cause = cause_q;

endmodule

// File: doc/core_local_irq_ctrl.md
Name: core_local_irq_ctrl

Overview:
- Parametrised local-interrupt controller for NUM_IRQ platform interrupt lines, mapped to causes 16 and above.
- Synchronises the lines, applies per-channel level or edge capture, delegation to M or S, and enable masking.
- Arbitrates the lines and presents one registered, stable interrupt request to the core controller with a take handshake.
- Sits beside the trap handler; the CSR file supplies configuration and reads pending state.

Parameters:
NUM_IRQ, 16, number of local interrupt channels (1..48)
SYNC_STAGES, 2, flops in each input synchroniser (>=2)
CAUSE_W, 6, width of the cause output; must hold 16+NUM_IRQ-1

Ports:
clk  in  1  core clock
rst_n  in  1  asynchronous active-low reset
irq_i  in  NUM_IRQ  raw asynchronous interrupt lines
cfg_edge  in  NUM_IRQ  per channel: 1 = rising-edge capture, 0 = level
cfg_ie  in  NUM_IRQ  per-channel enable
cfg_deleg  in  NUM_IRQ  per channel: 1 = delegated to S, 0 = M
priv  in  core_pkg::priv_e  current privilege
cfg_mie  in  1  mstatus.MIE
cfg_sie  in  1  mstatus.SIE
check_interrupt  in  1  controller is at an interruptible boundary
irq_take  in  1  controller accepts the presented request this cycle
clr_valid  in  1  CSR write clearing one pending bit
clr_idx  in  $clog2(NUM_IRQ)  channel to clear
irq_valid  out  1  request presented
irq_to_s  out  1  request target: 1 = S, 0 = M
irq_cause  out  CAUSE_W  16 + channel index
pending  out  NUM_IRQ  effective pending bits, for CSR read
overrun  out  NUM_IRQ  sticky overrun flags (optional feature)

Behaviour:
- Reset: all synchronisers, edge registers, pending and overrun are 0; FSM is IDLE; irq_valid=0, irq_to_s=0, irq_cause=0. Reset asserted mid-request drops irq_valid immediately.
- Sync: s[SYNC_STAGES-1] is the synchronised line.
- Level channel: pending[i] = sync[i] (combinational); irq_take and clr have no effect.
- Edge channel: pending[i] is set on a sync rising edge (sync & ~sync_d). It is cleared on a take of channel i, or on clr_valid with clr_idx==i.
- Edge channel, simultaneous set and clear: set wins.
- cfg_edge change: the edge pending register is cleared while cfg_edge[i]==0.
- Global enables: m_en = (priv==M) ? cfg_mie : 1. s_en = (priv==M) ? 0 : (priv==S) ? cfg_sie : 1.
- Eligibility: elig[i] = pending[i] & cfg_ie[i] & (cfg_deleg[i] ? s_en : m_en).
- Arbitration: eligible M-target channels beat eligible S-target channels. Within a target, the lowest index wins.
- IDLE: if check_interrupt and any channel is eligible, go to REQ at the next edge. Latch the chosen index, irq_to_s and irq_cause; irq_valid=1.
- REQ, outputs: irq_valid, irq_cause and irq_to_s are held stable. A newly eligible higher-priority channel does not preempt.
- REQ, take: irq_take=1 means a take of the latched channel; go to HOLD.
- REQ, withdraw: if irq_take=0 and the latched channel is no longer eligible, go to IDLE and drop irq_valid.
- REQ, simultaneous: take and ineligibility in the same cycle count as a take.
- HOLD: lasts 1 cycle with irq_valid=0, so the cleared pending bit settles; then IDLE.
- irq_take outside REQ is ignored.
- Latency, level: with SYNC_STAGES=2 and check_interrupt high, irq_valid rises after the 3rd rising clk edge, counting the edge that first samples irq_i high.
- Latency, edge: 4 edges. In general, SYNC_STAGES+1 for level and SYNC_STAGES+2 for edge.
- Width: irq_cause = 16 + index, zero-extended to CAUSE_W.

Optional Feature:
CORE_IRQ_OVERRUN_EN:
- Defined: overrun[i] is set when an edge-mode rising edge arrives while pending[i] is already 1. It is cleared only by clr_valid with clr_idx==i; set wins on collision.
- Undefined: overrun is tied to 0 and no flops are inferred.

Decomposition:
- core_pkg gains IRQ_LOCAL_BASE=16 and typedef irq_state_e {IRQ_IDLE, IRQ_REQ, IRQ_HOLD}; priv_e is reused.
- Sub-module core_irq_sync: a SYNC_STAGES-deep synchroniser plus delayed copy for edge detect, instantiated per channel.

Test Plan:
- Level: NUM_IRQ=16, ch3 level, ie=1, deleg=0, priv=U, irq_i[3]=1 -> irq_valid=1, cause=19, to_s=0 after 3 edges; irq_take -> HOLD; reasserts after the HOLD cycle while line high.
- Edge: ch5 edge, 1-cycle pulse, then take -> pending[5] cleared, one request only. Second pulse during REQ with overrun enabled -> overrun[5]=1 until clr_idx=5.
- Priority: ch2 (deleg=1) and ch9 (deleg=0), priv=S, sie=1 -> cause=25, to_s=0 first; after take, cause=18, to_s=1.
- Privilege masking: priv=M, mie=0 -> no request. mie=1 with only S-delegated ch1 pending -> no request (s_en=0).
- Withdraw: level ch4 in REQ, line drops with irq_take=0 -> irq_valid falls after sync latency, FSM IDLE, no take. Take and drop in the same cycle -> counted as take.
- Async reset in REQ -> irq_valid=0 and pending=0 immediately, before any clk edge.
